// File: rtl/aoi211_bist_checker.sv
// -----------------------------------------------------------------------------
// aoi211_bist_checker
//
// Self-test sequencer for an AOI211 gate, ZN = !((A1&A2)|B|C). It drives all
// 16 input combinations onto the gate and holds each one for SETTLE cycles.
// It then samples the gate's ZN for one cycle and compares it with the ideal
// value. It repeats the 16-vector sweep PASSES times and reports the result
// through a START/BUSY/DONE handshake.
//
// Optional feature: define AOI211_BIST_MISR_EN to add a 16-bit CRC-style
// signature (poly 0x1021, seed 0xFFFF) of every sampled ZN value.
//
// Ports:
//   CLK           rising-edge clock
//   RST           synchronous reset, active-high
//   START         run request, only looked at while idle
//   ABORT         cancels a run in progress (ignored while idle)
//   ZN_IN         ZN read back from the gate under test
//   STIM[3:0]     drive to the gate, bit order {C,B,A2,A1}
//   BUSY          high while a run is active
//   DONE          level, set when a run completes normally
//   FAIL          at least one mismatch seen in the last run
//   MISMATCH_CNT  saturating mismatch count
//   FIRST_FAIL    STIM vector of the first mismatch
//   SIGNATURE     (AOI211_BIST_MISR_EN only) response signature
// -----------------------------------------------------------------------------
module aoi211_bist_checker #(
    parameter int SETTLE = 2,
    parameter int PASSES = 1,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             ZN_IN,
    output logic [3:0]       STIM,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [CNT_W-1:0] MISMATCH_CNT,
    output logic [3:0]       FIRST_FAIL
`ifdef AOI211_BIST_MISR_EN
    ,
    output logic [15:0]      SIGNATURE
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0]       LAST_PASS   = 8'(PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [3:0]       stim_q, stim_d;        // doubles as the vector index
    logic [7:0]       pass_q, pass_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       first_q, first_d;
`ifdef AOI211_BIST_MISR_EN
    logic [15:0]      sig_q, sig_d;
`endif

    logic expected;
    logic mismatch;

    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        pass_d       = pass_q;
        settle_cnt_d = settle_cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
`ifdef AOI211_BIST_MISR_EN
        sig_d        = sig_q;
`endif

        expected = ~((stim_q[1] & stim_q[0]) | stim_q[2] | stim_q[3]);
        // Case inequality so that an X/Z read-back is treated as a mismatch.
        mismatch = (ZN_IN !== expected);

        case (state_q)
            ST_IDLE: begin
                // START wins over a simultaneous ABORT; ABORT is ignored here.
                if (START) begin
                    state_d      = ST_SETTLE;
                    stim_d       = 4'd0;
                    pass_d       = 8'd0;
                    settle_cnt_d = 4'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                    cnt_d        = '0;
                    first_d      = 4'd0;
`ifdef AOI211_BIST_MISR_EN
                    sig_d        = 16'hFFFF;
`endif
                end
            end

            ST_SETTLE: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    stim_d  = 4'd0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end

            ST_SAMPLE: begin
                if (ABORT) begin
                    // The compare of this cycle is dropped; partial results stay.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    stim_d  = 4'd0;
                end else begin
                    if (mismatch) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (!fail_q) begin
                            fail_d  = 1'b1;
                            first_d = stim_q;
                        end
                    end
`ifdef AOI211_BIST_MISR_EN
                    sig_d = {sig_q[14:0], 1'b0}
                          ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                          ^ {15'b0, ZN_IN};
`endif
                    if (stim_q == 4'd15 && pass_q == LAST_PASS) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stim_d  = 4'd0;
                    end else begin
                        // Vector 15 wraps to 0 naturally; that starts a new pass.
                        stim_d       = stim_q + 4'd1;
                        settle_cnt_d = 4'd0;
                        state_d      = ST_SETTLE;
                        if (stim_q == 4'd15) begin
                            pass_d = pass_q + 8'd1;
                        end
                    end
                end
            end

            default: begin
                // ST_DONE: results and DONE hold in IDLE until the next START.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            stim_q       <= 4'd0;
            pass_q       <= 8'd0;
            settle_cnt_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            cnt_q        <= '0;
            first_q      <= 4'd0;
`ifdef AOI211_BIST_MISR_EN
            sig_q        <= 16'hFFFF;
`endif
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            pass_q       <= pass_d;
            settle_cnt_q <= settle_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
`ifdef AOI211_BIST_MISR_EN
            sig_q        <= sig_d;
`endif
        end
    end

    assign STIM         = stim_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign FAIL         = fail_q;
    assign MISMATCH_CNT = cnt_q;
    assign FIRST_FAIL   = first_q;
`ifdef AOI211_BIST_MISR_EN
    assign SIGNATURE    = sig_q;
`endif

endmodule
